// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the MEM-stage data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W   = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = (1 << CNT_W) - 1;

    // Out-of-range latencies are clamped so the counter can never wrap.
    function automatic logic [CNT_W-1:0] cnt_init(input int latency);
        int lat;
        lat = (latency < LAT_MIN) ? LAT_MIN :
              (latency > LAT_MAX) ? LAT_MAX : latency;
        return CNT_W'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port 2**ADDR_W x 32 synchronous RAM with registered read.
// Revision : 1.0  initial release
// ============================================================================
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency load/store target that stalls the pipeline while busy.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = cnt_init(LATENCY);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        data_o_q, data_o_d;

    logic               req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_idx;
    logic [31:0]        mem_rdata;
    logic               unused_addr_bits;

    assign req              = MemRead_i | MemWrite_i;
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        data_o_d = data_o_q;
        mem_we   = 1'b0;
        mem_idx  = idx_q;
        stall_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // Read port follows the live address while idle so a LATENCY=1
                // load has its data ready by the completion cycle.
                mem_idx = addr_i[ADDR_W+1:2];
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    idx_d   = addr_i[ADDR_W+1:2];
                    wdata_d = data_i;
                    is_wr_d = MemWrite_i;
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_o = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_o_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            data_o_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            data_o_q <= data_o_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we & ~rst_i),
        .idx_i   (mem_idx),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign data_o = data_o_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed cycle-table bench for dmem_responder (LATENCY 4 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] dout;
    logic        stall;

    logic        rst1 = 1'b1, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [31:0] dout1;
    logic        stall1;

    int errs   = 0;
    int checks = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(4)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .MemRead_i(rd),
        .MemWrite_i(wr), .data_i(wdata), .data_o(dout), .stall_o(stall)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .MemRead_i(rd1),
        .MemWrite_i(wr1), .data_i(wdata1), .data_o(dout1), .stall_o(stall1)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr, wdata;
        logic        exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rep(input int n, input logic r, input logic rdv, input logic wrv,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic es, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.rd = rdv; v.wr = wrv; v.addr = a; v.wdata = d;
        v.exp_stall = es; v.exp_data = ed;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // One table row per clock cycle: drive after the edge, check at negedge.
    task automatic run(input bit sel, input string tag);
        foreach (vecs[i]) begin
            if (!sel) begin
                rst = vecs[i].rst; rd = vecs[i].rd; wr = vecs[i].wr;
                addr = vecs[i].addr; wdata = vecs[i].wdata;
            end else begin
                rst1 = vecs[i].rst; rd1 = vecs[i].rd; wr1 = vecs[i].wr;
                addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
            end
            @(negedge clk);
            chk($sformatf("%s[%0d].stall", tag, i), {31'b0, sel ? stall1 : stall},
                {31'b0, vecs[i].exp_stall});
            chk($sformatf("%s[%0d].data", tag, i), sel ? dout1 : dout, vecs[i].exp_data);
            @(posedge clk); #1;
        end
    endtask

    // Issues a request on the LATENCY=4 instance, counts stalled cycles, then drops it.
    task automatic xfer(input logic rdv, input logic wrv, input logic [31:0] a,
                        input logic [31:0] d, input int exp_cycles, input string name);
        int  n;
        bit  done;
        n = 0; done = 0;
        rd = rdv; wr = wrv; addr = a; wdata = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1;
            @(posedge clk); #1;
        end
        rd = 1'b0; wr = 1'b0;
        chk(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic chk_dout(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, dout, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit done;
        @(posedge clk); #1;

        // LATENCY=4: reset, store/load, alias, read+write collision, back-to-back
        rep(2, 1, 0, 0, 32'h0,    32'h0,        0, 32'h0);
        rep(3, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0);
        rep(4, 0, 0, 1, 32'h10,   32'hDEADBEEF, 1, 32'h0);
        rep(1, 0, 0, 1, 32'h10,   32'hDEADBEEF, 0, 32'h0);
        rep(4, 0, 1, 0, 32'h10,   32'h0,        1, 32'h0);
        rep(1, 0, 1, 0, 32'h10,   32'h0,        0, 32'h0);
        rep(1, 0, 0, 0, 32'h0,    32'h0,        0, 32'hDEADBEEF);
        rep(4, 0, 0, 1, 32'h1003, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
        rep(1, 0, 0, 1, 32'h1003, 32'hA5A5A5A5, 0, 32'hDEADBEEF);
        rep(4, 0, 1, 0, 32'h0,    32'h0,        1, 32'hDEADBEEF);
        rep(1, 0, 1, 0, 32'h0,    32'h0,        0, 32'hDEADBEEF);
        rep(4, 0, 1, 1, 32'h20,   32'h12345678, 1, 32'hA5A5A5A5);
        rep(1, 0, 1, 1, 32'h20,   32'h12345678, 0, 32'hA5A5A5A5);
        rep(1, 0, 0, 0, 32'h0,    32'h0,        0, 32'hA5A5A5A5);
        rep(4, 0, 1, 0, 32'h20,   32'h0,        1, 32'hA5A5A5A5);
        rep(1, 0, 1, 0, 32'h20,   32'h0,        0, 32'hA5A5A5A5);
        rep(1, 0, 0, 0, 32'h0,    32'h0,        0, 32'h12345678);
        run(1'b0, "lat4");

        // Reset in the middle of a store must drop the write.
        xfer(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4, "st40_stall_cycles");
        wr = 1'b1; addr = 32'h40; wdata = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'b0, stall}, 32'h0);
        chk("midrst_data", dout, 32'h0);
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 32'h40, 32'h0, 4, "ld40_stall_cycles");
        chk_dout("ld40_after_rst", 32'h0BADF00D);

        // Request dropped after acceptance still completes.
        wr = 1'b1; addr = 32'h44; wdata = 32'h22222222;
        @(negedge clk);
        chk("drop_accept_stall", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        n = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1;
            @(posedge clk); #1;
        end
        chk("drop_busy_cycles", 32'(n), 32'd3);
        xfer(1'b1, 1'b0, 32'h44, 32'h0, 4, "ld44_stall_cycles");
        chk_dout("ld44_data", 32'h22222222);

        // LATENCY=1: one stall cycle per request, no dead cycle between requests
        vecs.delete();
        rep(1, 1, 0, 0, 32'h0, 32'h0,        0, 32'h0);
        rep(1, 0, 0, 1, 32'h8, 32'hCAFEF00D, 1, 32'h0);
        rep(1, 0, 0, 1, 32'h8, 32'hCAFEF00D, 0, 32'h0);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        1, 32'h0);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        0, 32'h0);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        1, 32'hCAFEF00D);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        0, 32'hCAFEF00D);
        rep(1, 0, 0, 1, 32'h8, 32'h55AA55AA, 1, 32'hCAFEF00D);
        rep(1, 0, 0, 1, 32'h8, 32'h55AA55AA, 0, 32'hCAFEF00D);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        1, 32'hCAFEF00D);
        rep(1, 0, 1, 0, 32'h8, 32'h0,        0, 32'hCAFEF00D);
        rep(1, 0, 0, 0, 32'h0, 32'h0,        0, 32'h55AA55AA);
        run(1'b1, "lat1");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
